// File: rtl/shift_result_wb_stage.sv
// Execute-to-writeback stage: selects the Shifter or ALU result, queues it
// with its destination register in a 2-entry FIFO, drains it to the register
// file over a valid/ready handshake and commits Z/N flags on each retirement.
// Optional feature macro: WB_FWD_EN adds a combinational forwarding query port
// that returns the youngest queued result destined for a given register.
module shift_result_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_shift,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_we,
    output logic              flag_z,
    output logic              flag_n
`ifdef WB_FWD_EN
    ,
    input  logic [REG_AW-1:0] fwd_rd,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    logic [DATA_W-1:0] data_q [2];
    logic [REG_AW-1:0] rd_q   [2];
    logic              we_q   [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q,  count_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_n_q, flag_n_d;

    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] push_data_s;
    logic [DATA_W-1:0] head_data_s;

    // Handshakes, operand select and next-state pointer/count/flag values.
    always_comb begin
        push_s      = in_valid & (count_q != 2'd2);
        pop_s       = wb_ready & (count_q != 2'd0);
        push_data_s = in_sel ? in_shift : in_alu;
        head_data_s = data_q[rd_ptr_q];
        wr_ptr_d    = push_s ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d    = pop_s  ? ~rd_ptr_q : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (pop_s) begin
            flag_z_d = (head_data_s == {DATA_W{1'b0}});
            flag_n_d = head_data_s[DATA_W-1];
        end else begin
            flag_z_d = flag_z_q;
            flag_n_d = flag_n_q;
        end
    end

    // Queue state, entry storage and status flags; reset discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            data_q[0] <= {DATA_W{1'b0}};
            data_q[1] <= {DATA_W{1'b0}};
            rd_q[0]   <= {REG_AW{1'b0}};
            rd_q[1]   <= {REG_AW{1'b0}};
            we_q[0]   <= 1'b0;
            we_q[1]   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            if (push_s) begin
                data_q[wr_ptr_q] <= push_data_s;
                rd_q[wr_ptr_q]   <= in_rd;
                we_q[wr_ptr_q]   <= in_we;
            end
        end
    end

    // Head entry toward the register file; outputs are zero while empty.
    always_comb begin
        in_ready = (count_q != 2'd2);
        wb_valid = (count_q != 2'd0);
        flag_z   = flag_z_q;
        flag_n   = flag_n_q;
        if (count_q != 2'd0) begin
            wb_data = head_data_s;
            wb_rd   = rd_q[rd_ptr_q];
            wb_we   = we_q[rd_ptr_q];
        end else begin
            wb_data = {DATA_W{1'b0}};
            wb_rd   = {REG_AW{1'b0}};
            wb_we   = 1'b0;
        end
    end

`ifdef WB_FWD_EN
    logic young_hit_s;
    logic old_hit_s;

    // Forwarding lookup: the slot behind wr_ptr is the youngest entry and wins.
    always_comb begin
        young_hit_s = (count_q != 2'd0) & we_q[~wr_ptr_q] & (rd_q[~wr_ptr_q] == fwd_rd);
        old_hit_s   = (count_q == 2'd2) & we_q[wr_ptr_q]  & (rd_q[wr_ptr_q]  == fwd_rd);
        fwd_hit     = young_hit_s | old_hit_s;
        if (young_hit_s) begin
            fwd_data = data_q[~wr_ptr_q];
        end else if (old_hit_s) begin
            fwd_data = data_q[wr_ptr_q];
        end else begin
            fwd_data = {DATA_W{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_shift_result_wb_stage.sv
// Self-checking bench for shift_result_wb_stage: a scoreboard queue receives
// the expected {data, rd, we} whenever the bench drives an accepted push and
// is compared against the retirements observed on the write-back port.
// Forwarding checks are compiled only when WB_FWD_EN is defined.
module tb_shift_result_wb_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int EW     = DATA_W + REG_AW + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_sel, in_we;
    logic [DATA_W-1:0] in_alu, in_shift;
    logic [REG_AW-1:0] in_rd;
    logic              wb_valid, wb_ready, wb_we;
    logic [DATA_W-1:0] wb_data;
    logic [REG_AW-1:0] wb_rd;
    logic              flag_z, flag_n;
`ifdef WB_FWD_EN
    logic [REG_AW-1:0] fwd_rd;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];

    shift_result_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_alu(in_alu), .in_shift(in_shift), .in_rd(in_rd), .in_we(in_we),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_we(wb_we), .flag_z(flag_z), .flag_n(flag_n)
`ifdef WB_FWD_EN
        , .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    // Record every retirement that will happen on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1)
            obs_q.push_back({wb_data, wb_rd, wb_we});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] sh, input logic [REG_AW-1:0] rd,
                         input logic we);
        in_valid = 1'b1; in_sel = sel; in_alu = alu; in_shift = sh; in_rd = rd; in_we = we;
    endtask

    task automatic test_reset();
        logic [EW-1:0] e, o;
        rst_n = 1'b0;
        #2;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if ({flag_z, flag_n} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b%b want 00", flag_z, flag_n); end
        n_cmp++; if ({wb_data, wb_rd, wb_we} !== {EW{1'b0}}) begin n_err++; $display("FAIL reset_wb_bus got %h want 0", {wb_data, wb_rd, wb_we}); end
        @(posedge clk); #1 rst_n = 1'b1;
        // Set flag_n so the mid-stream reset has something to clear.
        wb_ready = 1'b1;
        drive(1'b0, 32'h8000_0000, 32'h0000_0000, 4'd1, 1'b1);
        exp_q.push_back({32'h8000_0000, 4'd1, 1'b1});
        cyc(); in_valid = 1'b0;
        cyc();
        n_cmp++; if (flag_n !== 1'b1) begin n_err++; $display("FAIL pre_reset_flag_n got %b want 1", flag_n); end
        n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL pre_reset_count got %0d want 1", obs_q.size()); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL pre_reset_entry got %h want %h", o, e); end
        end
        wb_ready = 1'b0;
        drive(1'b0, 32'h0000_0011, 32'h0, 4'd2, 1'b1); cyc();
        drive(1'b0, 32'h0000_0022, 32'h0, 4'd3, 1'b1); cyc();
        in_valid = 1'b0;
        n_cmp++; if ({wb_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL full_before_reset got %b want 10", {wb_valid, in_ready}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL midreset_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
        n_cmp++; if ({flag_z, flag_n} !== 2'b00) begin n_err++; $display("FAIL midreset_flags got %b%b want 00", flag_z, flag_n); end
        n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("FAIL midreset_wb_data got %h want 0", wb_data); end
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        cyc();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_discard got %b want 0", wb_valid); end
    endtask

    task automatic test_single();
        logic [EW-1:0] e, o;
        wb_ready = 1'b1;
        drive(1'b1, 32'h1234_5678, 32'h7800_0001, 4'd3, 1'b1);
        exp_q.push_back({32'h7800_0001, 4'd3, 1'b1});
        cyc(); in_valid = 1'b0;
        n_cmp++; if ({wb_valid, wb_data, wb_rd, wb_we} !== {1'b1, 32'h7800_0001, 4'd3, 1'b1}) begin
            n_err++; $display("FAIL single_head got v=%b d=%h rd=%0d we=%b want v=1 d=78000001 rd=3 we=1", wb_valid, wb_data, wb_rd, wb_we); end
        cyc();
        n_cmp++; if ({flag_z, flag_n, wb_valid} !== 3'b000) begin n_err++; $display("FAIL single_after_pop got z=%b n=%b v=%b want 000", flag_z, flag_n, wb_valid); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL single_sb got %h want %h", o, e); end
        end
        n_cmp++; if (exp_q.size() + obs_q.size() != 0) begin n_err++; $display("FAIL single_leftover got %0d want 0", exp_q.size() + obs_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] e, o;
        wb_ready = 1'b0;
        drive(1'b0, 32'h1, 32'hDEAD_0001, 4'd4, 1'b1); exp_q.push_back({32'h1, 4'd4, 1'b1}); cyc();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one got %b want 1", in_ready); end
        drive(1'b0, 32'h2, 32'hDEAD_0002, 4'd5, 1'b0); exp_q.push_back({32'h2, 4'd5, 1'b0}); cyc();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
        drive(1'b0, 32'h3, 32'hDEAD_0003, 4'd6, 1'b1); cyc(); cyc();
        n_cmp++; if ({in_ready, wb_data, wb_rd} !== {1'b0, 32'h1, 4'd4}) begin n_err++; $display("FAIL bp_hold got rdy=%b d=%h rd=%0d want 0 00000001 4", in_ready, wb_data, wb_rd); end
        in_valid = 1'b0; wb_ready = 1'b1;
        cyc(); cyc();
        n_cmp++; if ({wb_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_drained got %b want 01", {wb_valid, in_ready}); end
        n_cmp++; if (obs_q.size() != 2) begin n_err++; $display("FAIL bp_retired got %0d want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL bp_order got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flags();
        logic [EW-1:0] e, o;
        wb_ready = 1'b1;
        drive(1'b0, 32'h0, 32'hFFFF_FFFF, 4'd7, 1'b1); exp_q.push_back({32'h0, 4'd7, 1'b1});
        cyc(); in_valid = 1'b0; cyc();
        n_cmp++; if ({flag_z, flag_n} !== 2'b10) begin n_err++; $display("FAIL flags_zero got %b%b want 10", flag_z, flag_n); end
        drive(1'b1, 32'h0, 32'hFE00_0001, 4'd8, 1'b0); exp_q.push_back({32'hFE00_0001, 4'd8, 1'b0});
        cyc(); in_valid = 1'b0; cyc();
        n_cmp++; if ({flag_z, flag_n} !== 2'b01) begin n_err++; $display("FAIL flags_neg got %b%b want 01", flag_z, flag_n); end
        cyc();
        n_cmp++; if ({flag_z, flag_n} !== 2'b01) begin n_err++; $display("FAIL flags_hold got %b%b want 01", flag_z, flag_n); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL flags_sb got %h want %h", o, e); end
        end
        n_cmp++; if (exp_q.size() + obs_q.size() != 0) begin n_err++; $display("FAIL flags_leftover got %0d want 0", exp_q.size() + obs_q.size()); end
    endtask

    task automatic test_simultaneous();
        logic [EW-1:0] e, o;
        wb_ready = 1'b0;
        drive(1'b0, 32'hAAAA_5555, 32'h0, 4'd9, 1'b1); exp_q.push_back({32'hAAAA_5555, 4'd9, 1'b1}); cyc();
        wb_ready = 1'b1;
        drive(1'b1, 32'h0, 32'h5555_AAAA, 4'd10, 1'b1); exp_q.push_back({32'h5555_AAAA, 4'd10, 1'b1}); cyc();
        in_valid = 1'b0;
        n_cmp++; if ({wb_valid, in_ready, wb_data, wb_rd} !== {2'b11, 32'h5555_AAAA, 4'd10}) begin
            n_err++; $display("FAIL simul_head got v=%b r=%b d=%h rd=%0d want 1 1 5555aaaa 10", wb_valid, in_ready, wb_data, wb_rd); end
        cyc();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty got %b want 0", wb_valid); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL simul_sb got %h want %h", o, e); end
        end
        n_cmp++; if (exp_q.size() + obs_q.size() != 0) begin n_err++; $display("FAIL simul_leftover got %0d want 0", exp_q.size() + obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e, o;
        int cnt = 0;
        logic [DATA_W-1:0] a, s;
        for (int i = 0; i < 300; i++) begin
            a = $urandom(); s = $urandom();
            drive(1'($urandom_range(0, 1)), a, s, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            in_valid = 1'($urandom_range(0, 3) != 0);
            wb_ready = 1'($urandom_range(0, 2) != 0);
            n_cmp++; if ({in_ready, wb_valid} !== {cnt != 2, cnt != 0}) begin
                n_err++; $display("FAIL b2b_status cycle %0d got rdy=%b v=%b want count %0d", i, in_ready, wb_valid, cnt); end
            if (in_valid && cnt != 2) exp_q.push_back({in_sel ? s : a, in_rd, in_we});
            cnt = cnt + ((in_valid && cnt != 2) ? 1 : 0) - ((wb_ready && cnt != 0) ? 1 : 0);
            cyc();
        end
        in_valid = 1'b0; wb_ready = 1'b1;
        cyc(); cyc(); cyc();
        n_cmp++; if (exp_q.size() != obs_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL b2b_sb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef WB_FWD_EN
    task automatic test_forward();
        wb_ready = 1'b0;
        drive(1'b0, 32'hAAAA_0000, 32'h0, 4'd5, 1'b1); cyc();
        drive(1'b1, 32'h0, 32'hBBBB_0000, 4'd5, 1'b1); cyc();
        in_valid = 1'b0;
        fwd_rd = 4'd5; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'hBBBB_0000}) begin n_err++; $display("FAIL fwd_young got %b %h want 1 bbbb0000", fwd_hit, fwd_data); end
        fwd_rd = 4'd6; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL fwd_miss got %b %h want 0 0", fwd_hit, fwd_data); end
        wb_ready = 1'b1; cyc(); cyc();
        wb_ready = 1'b0;
        drive(1'b0, 32'hCCCC_0000, 32'h0, 4'd5, 1'b0); cyc();
        in_valid = 1'b0;
        fwd_rd = 4'd5; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL fwd_we0 got %b %h want 0 0", fwd_hit, fwd_data); end
        wb_ready = 1'b1; cyc(); cyc();
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        in_valid = 1'b0; in_sel = 1'b0; in_alu = '0; in_shift = '0; in_rd = '0; in_we = 1'b0;
        wb_ready = 1'b0;
`ifdef WB_FWD_EN
        fwd_rd = '0;
`endif
        test_reset();
        test_single();
        test_backpressure();
        test_flags();
        test_simultaneous();
        test_back_to_back();
`ifdef WB_FWD_EN
        test_forward();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
